// File: rtl/checkout_monitor_if.sv
// rtl/checkout_monitor_if.sv - scan/ack inputs and alarm/counter outputs of the checkout monitor
interface checkout_monitor_if;
    logic       scan_key;
    logic       stolen;
    logic       discount;
    logic       ack;
    logic       alarm;
    logic       alarm_blink;
    logic [3:0] item_cnt;
    logic [3:0] stolen_cnt;
    logic [3:0] discount_cnt;

    modport master (
        output scan_key, stolen, discount, ack,
        input  alarm, alarm_blink, item_cnt, stolen_cnt, discount_cnt
    );

    modport slave (
        input  scan_key, stolen, discount, ack,
        output alarm, alarm_blink, item_cnt, stolen_cnt, discount_cnt
    );
endinterface

// File: rtl/checkout_monitor.sv
// rtl/checkout_monitor.sv - scan counters with stolen-item alarm FSM and blinking alarm LED
module checkout_monitor #(
    parameter int BLINK_HALF = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    checkout_monitor_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ALERT, ST_CLEAR} state_t;

    localparam logic [24:0] BLINK_LAST = 25'(BLINK_HALF - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_scan_q;
    logic        r_ack_q;
    logic        r_scan_block;
    logic [3:0]  r_item_cnt;
    logic [3:0]  r_stolen_cnt;
    logic [3:0]  r_discount_cnt;
    logic [24:0] r_blink_cnt;
    logic        r_blink;
    logic        w_scan_pulse;
    logic        w_ack_pulse;
    logic        w_stolen_scan;

    // A scan_key still high from before reset must fall before it can count again.
    assign w_scan_pulse  = bus.scan_key & ~r_scan_q & ~r_scan_block;
    assign w_ack_pulse   = bus.ack & ~r_ack_q;
    assign w_stolen_scan = w_scan_pulse & bus.stolen;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_q     <= 1'b0;
            r_ack_q      <= 1'b0;
            r_scan_block <= 1'b1;
        end else begin
            r_scan_q <= bus.scan_key;
            r_ack_q  <= bus.ack;
            if (!bus.scan_key) begin
                r_scan_block <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_item_cnt     <= 4'd0;
            r_stolen_cnt   <= 4'd0;
            r_discount_cnt <= 4'd0;
        end else if (w_scan_pulse) begin
            if (r_item_cnt != 4'd15) begin
                r_item_cnt <= r_item_cnt + 4'd1;
            end
            if (bus.stolen && r_stolen_cnt != 4'd15) begin
                r_stolen_cnt <= r_stolen_cnt + 4'd1;
            end
            if (bus.discount && r_discount_cnt != 4'd15) begin
                r_discount_cnt <= r_discount_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_stolen_scan) w_next = ST_ALERT;
            end
            ST_ALERT: begin
                if (w_stolen_scan)    w_next = ST_ALERT;
                else if (w_ack_pulse) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (w_stolen_scan) w_next = ST_ALERT;
                else if (!bus.ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Blink phase restarts only on entry into ALERT, not on repeat stolen scans.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt <= 25'd0;
            r_blink     <= 1'b0;
        end else if (w_next == ST_ALERT && r_state != ST_ALERT) begin
            r_blink_cnt <= 25'd0;
            r_blink     <= 1'b1;
        end else if (w_next == ST_ALERT) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= 25'd0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + 25'd1;
            end
        end else begin
            r_blink_cnt <= 25'd0;
            r_blink     <= 1'b0;
        end
    end

    assign bus.alarm        = (r_state == ST_ALERT);
    assign bus.alarm_blink  = r_blink;
    assign bus.item_cnt     = r_item_cnt;
    assign bus.stolen_cnt   = r_stolen_cnt;
    assign bus.discount_cnt = r_discount_cnt;
endmodule

// File: tb/tb_checkout_monitor.sv
// tb/tb_checkout_monitor.sv - directed bench for checkout_monitor against a cycle-level reference model
module tb_checkout_monitor;
    localparam int BH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    checkout_monitor_if bus ();

    checkout_monitor #(.BLINK_HALF(BH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = alert, 2 = cleared-awaiting-ack-release.
    int m_state;
    int m_age;
    int m_item, m_stol, m_disc;
    bit m_scan_q, m_ack_q, m_armed;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_edge();
        bit sp, ap, ss;
        int nxt;
        if (reset) begin
            m_state = 0; m_age = 0; m_item = 0; m_stol = 0; m_disc = 0;
            m_scan_q = 0; m_ack_q = 0; m_armed = 0;
            return;
        end
        sp = bus.scan_key && !m_scan_q && m_armed;
        ap = bus.ack && !m_ack_q;
        ss = sp && bus.stolen;
        if (sp) begin
            m_item = sat15(m_item + 1);
            if (bus.stolen)   m_stol = sat15(m_stol + 1);
            if (bus.discount) m_disc = sat15(m_disc + 1);
        end
        nxt = m_state;
        if (ss)                      nxt = 1;
        else if (m_state == 1 && ap) nxt = 2;
        else if (m_state == 2 && !bus.ack) nxt = 0;
        if (nxt == 1 && m_state != 1) m_age = 0;
        else if (nxt == 1)            m_age = m_age + 1;
        else                          m_age = 0;
        m_state  = nxt;
        m_scan_q = bus.scan_key;
        m_ack_q  = bus.ack;
        if (!bus.scan_key) m_armed = 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        int exp_blink;
        exp_blink = (m_state == 1 && ((m_age / BH) % 2 == 0)) ? 1 : 0;
        check("model_alarm", int'(bus.alarm), (m_state == 1) ? 1 : 0);
        check("model_blink", int'(bus.alarm_blink), exp_blink);
        check("model_item", int'(bus.item_cnt), m_item);
        check("model_stolen", int'(bus.stolen_cnt), m_stol);
        check("model_discount", int'(bus.discount_cnt), m_disc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_in(input bit s, input bit st, input bit d, input bit a);
        bus.scan_key = s;
        bus.stolen   = st;
        bus.discount = d;
        bus.ack      = a;
    endtask

    task automatic check_all(input string name, input int a, input int b, input int i, input int s, input int d);
        check({name, "_alarm"}, int'(bus.alarm), a);
        check({name, "_blink"}, int'(bus.alarm_blink), b);
        check({name, "_item"}, int'(bus.item_cnt), i);
        check({name, "_stolen"}, int'(bus.stolen_cnt), s);
        check({name, "_discount"}, int'(bus.discount_cnt), d);
    endtask

    int blink_exp [9];

    initial begin
        n_checks = 0;
        n_errors = 0;
        blink_exp = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        set_in(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Discounted, not stolen
        set_in(1, 0, 1, 0);
        tick();
        check_all("disc_scan", 0, 0, 1, 0, 1);
        set_in(0, 1, 1, 0);
        tick();
        check("ignore_flags_off_pulse", int'(bus.stolen_cnt), 0);

        // Stolen scan and blink cadence
        set_in(1, 1, 0, 0);
        tick();
        check("blink_0", int'(bus.alarm_blink), blink_exp[0]);
        check("alarm_rise", int'(bus.alarm), 1);
        set_in(0, 0, 0, 0);
        for (int k = 1; k < 9; k++) begin
            tick();
            check($sformatf("blink_%0d", k), int'(bus.alarm_blink), blink_exp[k]);
        end
        set_in(0, 0, 0, 1);
        tick();
        check("ack_clear_alarm", int'(bus.alarm), 0);
        tick();
        check("clear_hold_alarm", int'(bus.alarm), 0);
        set_in(0, 0, 0, 0);
        tick();
        check_all("back_idle", 0, 0, 2, 1, 1);

        // Stolen scan and ack rise together in ALERT
        set_in(1, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        tick();
        set_in(1, 1, 0, 1);
        tick();
        check("stolen_wins_alarm", int'(bus.alarm), 1);
        check("stolen_wins_cnt", int'(bus.stolen_cnt), 3);
        set_in(0, 0, 0, 1);
        for (int k = 0; k < 6; k++) tick();
        check("still_alert", int'(bus.alarm), 1);

        // Re-entry into ALERT from CLEAR with ack held
        set_in(0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1);
        tick();
        check("to_clear", int'(bus.alarm), 0);
        set_in(1, 1, 0, 1);
        tick();
        check("reentry_alarm", int'(bus.alarm), 1);
        check("reentry_blink", int'(bus.alarm_blink), 1);
        set_in(0, 0, 0, 1);
        tick();
        tick();

        // Saturation
        for (int k = 0; k < 17; k++) begin
            set_in(1, 1, 1, 0);
            tick();
            set_in(0, 0, 0, 0);
            tick();
        end
        check_all("saturate", 1, int'(bus.alarm_blink), 15, 15, 15);

        // Reset mid-ALERT with a scan rising in the same cycle
        set_in(1, 1, 1, 1);
        reset = 1'b1;
        tick();
        check_all("reset_alert", 0, 0, 0, 0, 0);
        reset = 1'b0;
        set_in(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        check("held_through_reset", int'(bus.item_cnt), 0);
        set_in(0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) tick();
        check("held_ten_one_scan", int'(bus.item_cnt), 1);
        set_in(0, 0, 0, 0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/checkout_monitor.md
CHECKOUT_MONITOR -- requirements
Module: checkout_monitor

Interface
REQ-001 Parameter BLINK_HALF, default 25000000, gives the alarm_blink half-period in clk cycles; the range is 2 to 2^25-1.
REQ-002 Port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, width 1: synchronous, active-high reset.
REQ-004 Port scan_key, input, width 1: level-high "item scanned" request, already synchronised to clk.
REQ-005 Port stolen, input, width 1: stolen flag for the current item, from the upstream discounted/stolen detector.
REQ-006 Port discount, input, width 1: discount flag for the current item, from the same detector.
REQ-007 Port ack, input, width 1: level-high operator acknowledge, already synchronised.
REQ-008 Port alarm, output, width 1: stolen-item alarm is active.
REQ-009 Port alarm_blink, output, width 1: blinking copy of alarm, for an LED.
REQ-010 Port item_cnt, output, width 4: count of items scanned.
REQ-011 Port stolen_cnt, output, width 4: count of stolen items scanned.
REQ-012 Port discount_cnt, output, width 4: count of discounted items scanned.

Function
REQ-013 The block SHALL register scan_key and ack each cycle; scan_pulse = scan_key & ~scan_key_q, and ack_pulse = ack & ~ack_q.
REQ-014 A held scan_key SHALL produce exactly one scan_pulse per 0-to-1 transition.
REQ-015 On scan_pulse, stolen and discount SHALL be sampled in the same cycle; their values in any other cycle SHALL be ignored.
REQ-016 On scan_pulse, item_cnt SHALL increment by 1; stolen_cnt SHALL increment if stolen=1; discount_cnt SHALL increment if discount=1.
REQ-017 Each counter SHALL update independently, so stolen=1 and discount=1 together increment both.
REQ-018 All counters SHALL saturate at 15; a scan_pulse at 15 leaves that counter at 15, with no wrap-around.
REQ-019 Counter updates SHALL be visible one cycle after the scan_pulse cycle.
REQ-020 The FSM SHALL have three states: IDLE, ALERT and CLEAR; stolen_scan = scan_pulse & stolen.
REQ-021 IDLE: on stolen_scan go to ALERT; otherwise stay.
REQ-022 ALERT: on stolen_scan stay, because stolen wins over a simultaneous ack_pulse; else on ack_pulse go to CLEAR; else stay.
REQ-023 CLEAR: on stolen_scan go to ALERT; else if ack=0 go to IDLE; else stay.
REQ-024 alarm SHALL be 1 exactly when the state is ALERT, so the alarm rises on the cycle after a stolen_scan.
REQ-025 On each entry into ALERT, the blink counter SHALL clear to 0 and alarm_blink SHALL be 1.
REQ-026 While in ALERT, when the blink counter equals BLINK_HALF-1, alarm_blink SHALL toggle and the counter SHALL wrap to 0; otherwise the counter increments.
REQ-027 A stolen_scan while already in ALERT SHALL NOT restart the blink phase.
REQ-028 In IDLE and CLEAR, alarm_blink SHALL be 0 and the blink counter SHALL be held at 0.
REQ-029 ack and ack_pulse SHALL never change any counter.

Reset
REQ-030 When reset=1 at a clk edge, the block SHALL go to IDLE and clear to 0: item_cnt, stolen_cnt, discount_cnt, alarm, alarm_blink, the blink counter, scan_key_q and ack_q.
REQ-031 Reset SHALL take priority over every other event, including a scan_pulse or ack_pulse in the same cycle.
REQ-032 Reset asserted mid-ALERT SHALL drop alarm on the next edge.
REQ-033 If scan_key is held high through reset release, the block SHALL NOT count a scan until scan_key returns to 0 and rises again.

Verification (BLINK_HALF=4)
REQ-034 Scan with stolen=0, discount=1 -> next cycle item_cnt=1, discount_cnt=1, stolen_cnt=0, alarm=0.
REQ-035 Scan with stolen=1 -> next cycle alarm=1 and alarm_blink=1; alarm_blink then reads 1,1,1,1,0,0,0,0,1 over successive cycles; ack rise -> CLEAR with alarm=0; ack fall -> IDLE.
REQ-036 In ALERT, stolen scan and ack rise in the same cycle -> state stays ALERT, stolen_cnt increments, and the blink phase is unchanged.
REQ-037 In CLEAR with ack held, a stolen scan -> ALERT with alarm_blink=1 on re-entry.
REQ-038 Issue 17 scans with stolen=1 and discount=1 -> all counters read 15; scan_key held high for 10 cycles counts as one scan.
REQ-039 Reset pulse while in ALERT with counters nonzero -> all outputs 0 on the next edge; scan_key held high across reset -> no count.
